// File: rtl/uart_multibank_bridge.sv
// uart_multibank_bridge
//   Connects the uart2bus req/gnt register bus to NUM_BANKS synchronous RAM
//   ports. The high address bits select a bank and the low ADDR_W bits give
//   the word offset. Accesses to banks that do not exist, or with stray high
//   address bits set, are out of range (OOR): OOR writes are dropped and OOR
//   reads return OOR_DATA. Protocol misuse bumps a saturating error counter.
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   bus_addr     in   [BUS_AW]   register-bus address
//   bus_wr_data  in   [DATA_W]   register-bus write data
//   bus_write    in   1-cycle write strobe (legal only while granted)
//   bus_read     in   1-cycle read strobe (legal only while granted)
//   bus_req      in   bus access request
//   bus_gnt      out  bus access grant
//   bus_rd_data  out  [DATA_W]   read data, held until the next read completes
//   grant_hold   in   blocks new grants, never revokes a held one
//   mem_addr     out  [ADDR_W]   shared RAM address
//   mem_wr_data  out  [DATA_W]   shared RAM write data
//   mem_en       out  [NUM_BANKS] per-bank enable, one-hot or zero
//   mem_we       out  [NUM_BANKS] per-bank write enable
//   mem_rd_data  in   [NUM_BANKS*DATA_W] bank b at [b*DATA_W +: DATA_W]
//   err_count    out  [8]        protocol-error count, saturates at 255
module uart_multibank_bridge #(
  parameter int                DATA_W    = 8,
  parameter int                BUS_AW    = 16,
  parameter int                ADDR_W    = 10,
  parameter int                NUM_BANKS = 2,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] OOR_DATA  = 8'hFF
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [BUS_AW-1:0]           bus_addr,
  input  logic [DATA_W-1:0]           bus_wr_data,
  input  logic                        bus_write,
  input  logic                        bus_read,
  input  logic                        bus_req,
  output logic                        bus_gnt,
  output logic [DATA_W-1:0]           bus_rd_data,
  input  logic                        grant_hold,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wr_data,
  output logic [NUM_BANKS-1:0]        mem_en,
  output logic [NUM_BANKS-1:0]        mem_we,
  input  logic [NUM_BANKS*DATA_W-1:0] mem_rd_data,
  output logic [7:0]                  err_count
);

  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int HI_LSB    = ADDR_W + BANK_BITS;
  // Ones on every address bit above the bank field; zero when none exist.
  localparam logic [BUS_AW-1:0] HI_MASK = ~((BUS_AW'(1) << HI_LSB) - BUS_AW'(1));

  typedef enum logic [1:0] {IDLE, GRANT, RD_WAIT} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [DATA_W-1:0] bank_slice(
    input logic [NUM_BANKS*DATA_W-1:0] bus,
    input logic [BANK_BITS-1:0]        b
  );
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (b == BANK_BITS'(i)) r = bus[i*DATA_W +: DATA_W];
    return r;
  endfunction

  state_t                 state, state_nxt;
  logic                   acc_wr, acc_rd, err_hit, gnt_nxt;
  logic [2:0]             rd_cnt;
  logic [BANK_BITS-1:0]   dec_bank;
  logic [ADDR_W-1:0]      dec_off;
  logic                   dec_oor;
  logic [NUM_BANKS-1:0]   dec_oh;

  logic [RD_LAT:0]        rd_vld_p;
  logic [BANK_BITS-1:0]   rd_bank_p [RD_LAT+1];
  logic                   rd_oor_p  [RD_LAT+1];

  assign dec_bank = bus_addr[ADDR_W +: BANK_BITS];
  assign dec_off  = bus_addr[ADDR_W-1:0];
  assign dec_oor  = (|(bus_addr & HI_MASK)) ||
                    ({1'b0, dec_bank} >= (BANK_BITS+1)'(NUM_BANKS));
  assign dec_oh   = dec_oor ? '0 : (NUM_BANKS'(1) << dec_bank);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_wr    = 1'b0;
    acc_rd    = 1'b0;
    err_hit   = 1'b0;
    case (state)
      IDLE: begin
        err_hit = bus_write | bus_read;
        if (bus_req && !grant_hold) state_nxt = GRANT;
      end
      GRANT: begin
        // A simultaneous write and read keeps the write and drops the read.
        acc_wr  = bus_write;
        acc_rd  = bus_read & ~bus_write;
        err_hit = bus_write & bus_read;
        if (acc_rd)        state_nxt = RD_WAIT;
        else if (!bus_req) state_nxt = IDLE;
      end
      RD_WAIT: begin
        err_hit = bus_write | bus_read;
        if (rd_cnt == 3'd0) state_nxt = bus_req ? GRANT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    gnt_nxt = (state_nxt == GRANT) || ((state_nxt == RD_WAIT) && bus_req);
  end

  // Stage p0: RAM request issue, grant and error bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_gnt     <= 1'b0;
      err_count   <= 8'd0;
      rd_cnt      <= 3'd0;
      mem_en      <= '0;
      mem_we      <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      rd_vld_p    <= '0;
    end else begin
      bus_gnt  <= gnt_nxt;
      if (err_hit) err_count <= sat_inc(err_count);
      // RD_WAIT spans RD_LAT+1 cycles: counts RD_LAT down to zero.
      if (acc_rd)                                  rd_cnt <= 3'(RD_LAT);
      else if (state == RD_WAIT && rd_cnt != 3'd0) rd_cnt <= rd_cnt - 3'd1;
      mem_en   <= (acc_wr || acc_rd) ? dec_oh : '0;
      mem_we   <= acc_wr ? dec_oh : '0;
      if ((acc_wr || acc_rd) && !dec_oor) mem_addr <= dec_off;
      if (acc_wr && !dec_oor)             mem_wr_data <= bus_wr_data;
      rd_vld_p <= {rd_vld_p[RD_LAT-1:0], acc_rd};
    end
  end

  // Stages p1..pRD_LAT: bank index and OOR flag travel with the read
  always_ff @(posedge clock) begin
    rd_bank_p[0] <= dec_bank;
    rd_oor_p[0]  <= dec_oor;
    for (int k = 1; k <= RD_LAT; k++) begin
      rd_bank_p[k] <= rd_bank_p[k-1];
      rd_oor_p[k]  <= rd_oor_p[k-1];
    end
  end

  // Final stage: RAM data is valid in the cycle stage RD_LAT is occupied
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      bus_rd_data <= '0;
    else if (rd_vld_p[RD_LAT])
      bus_rd_data <= rd_oor_p[RD_LAT] ? OOR_DATA
                                      : bank_slice(mem_rd_data, rd_bank_p[RD_LAT]);
  end

endmodule

// File: tb/tb_uart_multibank_bridge.sv
// Bench for uart_multibank_bridge: two instances sharing one stimulus,
// A (NUM_BANKS=2, RD_LAT=1) and B (NUM_BANKS=3, RD_LAT=2), each compared
// every cycle against a cycle-numbered behavioural model, plus literal
// expectations for hand-worked scenarios.
module tb_uart_multibank_bridge;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wr_data;
  logic        bus_write, bus_read, bus_req, grant_hold;
  logic [23:0] rd_word;

  logic        a_gnt, b_gnt;
  logic [7:0]  a_rd, b_rd, a_wd, b_wd, a_err, b_err;
  logic [9:0]  a_ma, b_ma;
  logic [1:0]  a_en, a_we;
  logic [2:0]  b_en, b_we;

  always #5 clock = ~clock;

  uart_multibank_bridge #(.NUM_BANKS(2), .RD_LAT(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_write(bus_write), .bus_read(bus_read), .bus_req(bus_req), .bus_gnt(a_gnt),
    .bus_rd_data(a_rd), .grant_hold(grant_hold), .mem_addr(a_ma), .mem_wr_data(a_wd),
    .mem_en(a_en), .mem_we(a_we), .mem_rd_data(rd_word[15:0]), .err_count(a_err));

  uart_multibank_bridge #(.NUM_BANKS(3), .RD_LAT(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_write(bus_write), .bus_read(bus_read), .bus_req(bus_req), .bus_gnt(b_gnt),
    .bus_rd_data(b_rd), .grant_hold(grant_hold), .mem_addr(b_ma), .mem_wr_data(b_wd),
    .mem_en(b_en), .mem_we(b_we), .mem_rd_data(rd_word), .err_count(b_err));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int LAT [2] = '{1, 2};
  int NB  [2] = '{2, 3};
  int BB  [2] = '{1, 2};

  bit       m_granted [2];
  int       m_busy_until [2];   // last cycle of the read wait; -1 when none
  bit       m_pend [2];
  int       m_pbank [2];
  bit       m_poor [2];
  bit       e_gnt [2];
  bit [7:0] e_rd [2], e_wd [2], e_err [2], e_en [2], e_we [2];
  bit [9:0] e_ma [2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_granted[i] = 0; m_busy_until[i] = -1; m_pend[i] = 0;
      e_gnt[i] = 0; e_rd[i] = 0; e_wd[i] = 0; e_err[i] = 0;
      e_en[i] = 0; e_we[i] = 0; e_ma[i] = 0;
    end
  endtask

  // Consumes the inputs of cycle `cyc` and produces outputs for cyc+1.
  task automatic model_step(input int i);
    int bank;
    bit oor, wr, rd, err, do_wr, do_rd;
    wr = bus_write; rd = bus_read; err = 0; do_wr = 0; do_rd = 0;
    bank = (int'(bus_addr) >> 10) & ((1 << BB[i]) - 1);
    oor  = ((int'(bus_addr) >> (10 + BB[i])) != 0) || (bank >= NB[i]);
    if (m_pend[i] && cyc == m_busy_until[i]) begin
      e_rd[i]   = m_poor[i] ? 8'hFF : rd_word[m_pbank[i]*8 +: 8];
      m_pend[i] = 0;
    end
    if (cyc <= m_busy_until[i]) begin
      err = wr | rd;
      if (cyc == m_busy_until[i]) m_granted[i] = bus_req;
      e_gnt[i] = bus_req;
    end else if (m_granted[i]) begin
      do_wr = wr;
      do_rd = rd & !wr;
      err   = wr & rd;
      if (do_rd) begin
        m_busy_until[i] = cyc + 1 + LAT[i];
        m_pend[i] = 1; m_pbank[i] = bank; m_poor[i] = oor;
      end else begin
        m_granted[i] = bus_req;
      end
      e_gnt[i] = bus_req;
    end else begin
      err = wr | rd;
      m_granted[i] = bus_req && !grant_hold;
      e_gnt[i] = m_granted[i];
    end
    if (err && e_err[i] != 8'd255) e_err[i] = e_err[i] + 8'd1;
    e_en[i] = 0; e_we[i] = 0;
    if ((do_wr || do_rd) && !oor) begin
      e_en[i] = 8'(1 << bank);
      e_ma[i] = bus_addr[9:0];
      if (do_wr) begin e_we[i] = e_en[i]; e_wd[i] = bus_wr_data; end
    end
  endtask

  always @(posedge clock) begin
    if (!reset_n) model_clear();
    else for (int i = 0; i < 2; i++) model_step(i);
    cyc = cyc + 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (!reset_n) begin
      check("rst_a_gnt", a_gnt, 0); check("rst_a_rd", a_rd, 0);
      check("rst_a_en", a_en, 0);   check("rst_a_we", a_we, 0);
      check("rst_a_ma", a_ma, 0);   check("rst_a_wd", a_wd, 0);
      check("rst_a_err", a_err, 0);
      check("rst_b_gnt", b_gnt, 0); check("rst_b_rd", b_rd, 0);
      check("rst_b_en", b_en, 0);   check("rst_b_we", b_we, 0);
      check("rst_b_ma", b_ma, 0);   check("rst_b_wd", b_wd, 0);
      check("rst_b_err", b_err, 0);
    end else begin
      check("a_gnt", a_gnt, e_gnt[0]); check("a_rd", a_rd, e_rd[0]);
      check("a_en", a_en, e_en[0]);    check("a_we", a_we, e_we[0]);
      check("a_ma", a_ma, e_ma[0]);    check("a_wd", a_wd, e_wd[0]);
      check("a_err", a_err, e_err[0]);
      check("b_gnt", b_gnt, e_gnt[1]); check("b_rd", b_rd, e_rd[1]);
      check("b_en", b_en, e_en[1]);    check("b_we", b_we, e_we[1]);
      check("b_ma", b_ma, e_ma[1]);    check("b_wd", b_wd, e_wd[1]);
      check("b_err", b_err, e_err[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    model_clear();
    reset_n = 0; bus_addr = 0; bus_wr_data = 0; bus_write = 0; bus_read = 0;
    bus_req = 0; grant_hold = 0; rd_word = 24'h11223C;
    repeat (3) step();
    check("lit_rst_err", a_err, 8'd0);
    reset_n = 1;
    step();

    // grant_hold blocks the grant; a strobe in IDLE is an error
    grant_hold = 1; bus_req = 1;
    repeat (4) step();
    check("lit_hold_gnt_a", a_gnt, 0);
    check("lit_hold_gnt_b", b_gnt, 0);
    bus_write = 1; bus_addr = 16'h0000;
    step();
    bus_write = 0;
    check("lit_idle_err_a", a_err, 8'd1);
    check("lit_idle_err_b", b_err, 8'd1);
    grant_hold = 0;
    step();
    check("lit_gnt_a", a_gnt, 1);

    // write 0x0405 <- 0xA5
    bus_addr = 16'h0405; bus_wr_data = 8'hA5; bus_write = 1;
    step();
    bus_write = 0;
    check("lit_wr_en", a_en, 2'b10);
    check("lit_wr_we", a_we, 2'b10);
    check("lit_wr_addr", a_ma, 10'h005);
    check("lit_wr_data", a_wd, 8'hA5);
    check("lit_wr_en_b", b_en, 3'b010);
    step();
    check("lit_wr_one_cycle", a_en, 2'b00);

    // read 0x0005, bank 0 returns 0x3C
    bus_addr = 16'h0005; bus_read = 1;
    step();
    bus_read = 0;
    check("lit_rd_en", a_en, 2'b01);
    check("lit_rd_we", a_we, 2'b00);
    step();
    check("lit_rd_not_early", a_rd, 8'h00);
    step();
    check("lit_rd_lat3", a_rd, 8'h3C);
    check("lit_rd_gnt", a_gnt, 1);
    step();
    check("lit_rd_lat4_b", b_rd, 8'h3C);

    // OOR read 0x0800 (bank 2 exists only in B)
    bus_addr = 16'h0800; bus_read = 1;
    step();
    bus_read = 0;
    check("lit_oor_rd_en", a_en, 2'b00);
    check("lit_b2_rd_en", b_en, 3'b100);
    repeat (2) step();
    check("lit_oor_rd_data", a_rd, 8'hFF);
    step();
    check("lit_b2_rd_data", b_rd, 8'h11);
    check("lit_oor_err", a_err, 8'd1);

    // OOR write 0xF000
    bus_addr = 16'hF000; bus_wr_data = 8'h99; bus_write = 1;
    step();
    bus_write = 0;
    check("lit_oor_wr_en_a", a_en, 2'b00);
    check("lit_oor_wr_en_b", b_en, 3'b000);
    check("lit_oor_wr_hold", a_wd, 8'hA5);
    check("lit_oor_wr_err", a_err, 8'd1);
    step();

    // write + read together
    bus_addr = 16'h0003; bus_wr_data = 8'h77; bus_write = 1; bus_read = 1;
    step();
    bus_write = 0; bus_read = 0;
    check("lit_sim_en", a_en, 2'b01);
    check("lit_sim_we", a_we, 2'b01);
    check("lit_sim_err", a_err, 8'd2);
    repeat (3) step();
    check("lit_sim_no_rd", a_rd, 8'hFF);

    // strobe during RD_WAIT
    bus_addr = 16'h0401; bus_read = 1;
    step();
    bus_read = 0;
    bus_addr = 16'h0002; bus_wr_data = 8'h55; bus_write = 1;
    step();
    bus_write = 0;
    check("lit_rdw_en", a_en, 2'b00);
    check("lit_rdw_err", a_err, 8'd3);
    step();
    check("lit_rdw_rd", a_rd, 8'h22);
    step();
    check("lit_rdw_rd_b", b_rd, 8'h22);
    step();

    // reset in the middle of a read on B (RD_LAT=2)
    bus_addr = 16'h0000; bus_read = 1;
    step();
    bus_read = 0;
    step();
    reset_n = 0;
    step();
    check("lit_mid_rst_rd", b_rd, 8'h00);
    check("lit_mid_rst_err", b_err, 8'h00);
    reset_n = 1;
    repeat (4) step();
    check("lit_aborted_rd_b", b_rd, 8'h00);
    check("lit_aborted_rd_a", a_rd, 8'h00);

    // 300 errors saturate
    bus_req = 0;
    repeat (2) step();
    bus_write = 1;
    repeat (300) step();
    bus_write = 0;
    step();
    check("lit_sat_a", a_err, 8'd255);
    check("lit_sat_b", b_err, 8'd255);

    // randomized traffic
    reset_n = 0;
    repeat (2) step();
    reset_n = 1;
    for (int n = 0; n < 4000; n++) begin
      int r;
      rd_word = 24'($urandom);
      if ($urandom_range(0, 9) == 0) bus_req = ~bus_req;
      grant_hold = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 99);
      bus_write = bus_req && (r < 20);
      bus_read  = bus_req && (r >= 15) && (r < 40);
      if ($urandom_range(0, 3) == 0) bus_addr = 16'($urandom);
      else                           bus_addr = 16'($urandom_range(0, 16'h0FFF));
      bus_wr_data = 8'($urandom);
      step();
    end
    bus_write = 0; bus_read = 0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
